// File: rtl/cpu_pkg.sv
// cpu_pkg
// Definitions shared by the CPU and the memory beside it.
//   DEFAULT_ADDR_WIDTH : default word-address width (depth = 2^width)
//   DEFAULT_DATA_WIDTH : default word width in bits
//   PC_RESET           : CPU reset PC. The memory reuses it as the first
//                        writable address, so the words below the first
//                        fetch can be made read-only.
//   mem_state_t        : memory FSM encoding. The state bit doubles as the
//                        memory's ready output.
package cpu_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 6;
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int PC_RESET           = 8;

  typedef enum logic {
    MEM_INIT  = 1'b0,
    MEM_READY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/memory_mem_array.sv
// mem_array
// Plain single-port 1R1W synchronous storage. The read data is registered,
// and a write takes priority over the read of the same word (write-first).
// Ports:
//   clk   : clock, all updates on the rising edge
//   we    : write enable
//   addr  : word address, shared by read and write
//   wdata : write data
//   rdata : registered read data, valid the cycle after addr is presented
module mem_array #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // The storage has no reset. The owner clears it through the write port.
  // A write forwards its own data to rdata, so a colliding read returns
  // the new word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/memory.sv
// memory
// Single-port data/program memory beside the CPU. After reset, a clear
// sweep writes zero to every word, one word per cycle. After the sweep, the
// memory serves one CPU access per cycle and registers the read data.
// Ports:
//   clk   : clock, all updates on the rising edge
//   rst_n : synchronous reset. It is active-high despite its name.
//   we    : write enable (CPU mem_we)
//   addr  : word address (CPU mem_addr)
//   data  : write data (CPU mem_data)
//   out   : registered read data (CPU mem_in)
//   ready : high once the sweep is done. CPU accesses are honoured only then.
//   fault : sticky flag for a write to a protected address. This port is
//           present only when MEMORY_PROTECT_EN is defined.
// Configuration:
//   MEMORY_PROTECT_EN : when defined, writes to addresses below PROT_LIMIT
//                       are suppressed and set fault.
module memory
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PROT_LIMIT = PC_RESET
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  ready
`ifdef MEMORY_PROTECT_EN
  ,
  output logic                  fault
`endif
);

`ifdef MEMORY_PROTECT_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] PROT_ADDR = ADDR_WIDTH'(PROT_LIMIT);

  mem_state_t            state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  blocked;
  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_wdata;

  // A CPU write into the protected low region is dropped. Without
  // protection, this term is a constant zero.
  assign blocked = PROT_ON && (addr < PROT_ADDR);

  // The state bit is ready itself, so ready is a registered output with
  // no decode.
  assign ready = (state == MEM_READY);

  // The array port is owned by the sweep during reset and INIT. The
  // sweep always writes zero, so write-first forwarding keeps out at zero
  // for the whole sweep. The reset edge itself also loads out with zero.
  // Any CPU write in that window is discarded.
  always_comb begin
    arr_we    = 1'b1;
    arr_addr  = cnt;
    arr_wdata = '0;
    if (rst_n) begin
      arr_addr = '0;
    end else if (state == MEM_READY) begin
      arr_we    = we && !blocked;
      arr_addr  = addr;
      arr_wdata = data;
    end
  end

  // Two-state FSM. The sweep ends on the all-ones count, which clears the
  // last word on the same edge that raises ready. After that, the memory
  // stays in READY until the next reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= MEM_INIT;
      cnt   <= '0;
`ifdef MEMORY_PROTECT_EN
      fault <= 1'b0;
`endif
    end else begin
      case (state)
        MEM_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state <= MEM_READY;
          end
        end
        MEM_READY: begin
`ifdef MEMORY_PROTECT_EN
          if (we && blocked) begin
            fault <= 1'b1;
          end
`endif
        end
        default: state <= MEM_INIT;
      endcase
    end
  end

  mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(out)
  );

endmodule

// File: tb/tb_memory.sv
// tb_memory
// Directed bench for memory. Inputs change 1 ns after each rising edge.
// Outputs are checked at the same point, after they have settled.
// The bench also builds with MEMORY_PROTECT_EN defined, which enables the
// protection checks and connects the fault port.
module tb_memory;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [5:0]  addr;
  logic [15:0] data;
  logic [15:0] out;
  logic        ready;
`ifdef MEMORY_PROTECT_EN
  logic        fault;
`endif

  int checks   = 0;
  int failures = 0;
  int rise;
  int bad_out;

  memory dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .addr (addr),
    .data (data),
    .out  (out),
    .ready(ready)
`ifdef MEMORY_PROTECT_EN
    ,
    .fault(fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for the next rising edge, then steps just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one access, then lets one rising edge pass.
  task automatic applyStimulus(input logic w, input logic [5:0] a,
                               input logic [15:0] d);
    we   = w;
    addr = a;
    data = d;
    step();
  endtask

  // Compares one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts the edges, after reset is released, until ready rises.
  // During those edges, it counts any cycle where out is non-zero.
  // we is cleared before the 64th edge, so a held write cannot land once
  // the memory is ready. The wait is bounded at 70 edges.
  task automatic run_sweep(output int rise_at, output int bad);
    rise_at = 0;
    bad     = 0;
    for (int i = 1; i <= 70; i++) begin
      if (i == 64) we = 1'b0;
      step();
      if (ready === 1'b1) begin
        rise_at = i;
        break;
      end
      if (out !== 16'h0000) bad++;
    end
    we = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    rst_n = 1'b1;
    we    = 1'b0;
    addr  = '0;
    data  = '0;
    step();
    step();
    checkOutput("reset_ready", 32'(ready), 32'h0);
    checkOutput("reset_out", 32'(out), 32'h0);
`ifdef MEMORY_PROTECT_EN
    checkOutput("reset_fault", 32'(fault), 32'h0);
`endif

    // Sweep with a write held throughout. The write must be ignored.
    we    = 1'b1;
    addr  = 6'd5;
    data  = 16'hBEEF;
    rst_n = 1'b0;
    run_sweep(rise, bad_out);
    checkOutput("sweep_len", 32'(rise), 32'd64);
    checkOutput("sweep_out_zero", 32'(bad_out), 32'd0);
    applyStimulus(1'b0, 6'd5, 16'h0000);
    checkOutput("addr5_cleared", 32'(out), 32'h0000);

    // Write, then read. There must be no combinational path from addr to out.
    applyStimulus(1'b1, 6'd9, 16'h1234);
    applyStimulus(1'b0, 6'd20, 16'h0000);
    checkOutput("read20_zero", 32'(out), 32'h0000);
    addr = 6'd9;
    #1;
    checkOutput("no_comb_path", 32'(out), 32'h0000);
    step();
    checkOutput("read9", 32'(out), 32'h1234);

    // Write-first collision at the top address, then read it back.
    applyStimulus(1'b1, 6'd63, 16'hA5A5);
    checkOutput("write_first63", 32'(out), 32'hA5A5);
    applyStimulus(1'b0, 6'd0, 16'h0000);
    applyStimulus(1'b0, 6'd63, 16'h0000);
    checkOutput("read63", 32'(out), 32'hA5A5);

    // Back-to-back writes, then back-to-back reads.
    applyStimulus(1'b1, 6'd10, 16'd1);
    applyStimulus(1'b1, 6'd11, 16'd2);
    applyStimulus(1'b1, 6'd12, 16'd3);
    applyStimulus(1'b0, 6'd12, 16'd0);
    checkOutput("b2b_read12", 32'(out), 32'd3);
    applyStimulus(1'b0, 6'd11, 16'd0);
    checkOutput("b2b_read11", 32'(out), 32'd2);
    applyStimulus(1'b0, 6'd10, 16'd0);
    checkOutput("b2b_read10", 32'(out), 32'd1);

    // Reset during a sweep, 20 cycles in.
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) step();
    checkOutput("midsweep_ready", 32'(ready), 32'h0);
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    run_sweep(rise, bad_out);
    checkOutput("resweep_len", 32'(rise), 32'd64);
    checkOutput("resweep_out_zero", 32'(bad_out), 32'd0);

    // Reset during operation, after storing a word.
    applyStimulus(1'b1, 6'd40, 16'hFFFF);
    applyStimulus(1'b0, 6'd40, 16'h0000);
    checkOutput("read40_stored", 32'(out), 32'hFFFF);
    rst_n = 1'b1;
    step();
    checkOutput("rst_out_zero", 32'(out), 32'h0000);
    rst_n = 1'b0;
    run_sweep(rise, bad_out);
    checkOutput("opreset_len", 32'(rise), 32'd64);
    checkOutput("opreset_out_zero", 32'(bad_out), 32'd0);
    applyStimulus(1'b0, 6'd40, 16'h0000);
    checkOutput("read40_cleared", 32'(out), 32'h0000);

    // Writes to the low region, which is protected only when the macro is defined.
    applyStimulus(1'b1, 6'd3, 16'h7777);
`ifdef MEMORY_PROTECT_EN
    checkOutput("blocked_out_old", 32'(out), 32'h0000);
    checkOutput("fault_set", 32'(fault), 32'h1);
`endif
    applyStimulus(1'b0, 6'd3, 16'h0000);
`ifdef MEMORY_PROTECT_EN
    checkOutput("read3_protected", 32'(out), 32'h0000);
`else
    checkOutput("read3_written", 32'(out), 32'h7777);
`endif
    applyStimulus(1'b1, 6'd8, 16'h7777);
    applyStimulus(1'b0, 6'd8, 16'h0000);
    checkOutput("read8", 32'(out), 32'h7777);
`ifdef MEMORY_PROTECT_EN
    checkOutput("fault_sticky", 32'(fault), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
